// File: rtl/cb_edge_arb_if.sv
// Event handshake bundle for cb_edge_arb: the arbiter drives one edge event
// at a time (channel, type, timestamp) under a valid/ready handshake.
interface cb_edge_arb_if #(
    parameter int CH_NUM = 4,
    parameter int TS_W   = 16
);
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic            evt_vld;
    logic            evt_rdy;
    logic [CH_W-1:0] evt_ch;
    logic            evt_type;
    logic [TS_W-1:0] evt_ts;

    modport master (
        output evt_vld,
        output evt_ch,
        output evt_type,
        output evt_ts,
        input  evt_rdy
    );

    modport slave (
        input  evt_vld,
        input  evt_ch,
        input  evt_type,
        input  evt_ts,
        output evt_rdy
    );
endinterface

// File: rtl/cb_edge_arb.sv
// cb_edge_arb: per-channel edge detector with round-robin event arbiter.
// Each asynchronous sig_in bit is synchronised, edge-qualified by edge_sel and
// parked in a one-deep pending slot; a two-state FSM hands pending events to
// the consumer one per cycle. A second edge on a still-pending channel is
// dropped and flagged in the sticky ovf_flag.
// Optional feature macro: CB_EDGE_ARB_TS_EN -- when defined, a free-running
// timestamp counter is kept and evt_ts carries the time of edge detection;
// when undefined, all timestamp storage is removed and evt_ts is tied to 0.
module cb_edge_arb #(
    parameter int U_DLY  = 1,
    parameter int CH_NUM = 4,
    parameter int TS_W   = 16
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [CH_NUM-1:0]   sig_in,
    input  logic [2*CH_NUM-1:0] edge_sel,
    output logic [CH_NUM-1:0]   ovf_flag,
    input  logic                ovf_clr,
    cb_edge_arb_if.master       evt
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    // U_DLY is kept for parameter compatibility with existing instantiations;
    // registers here update with plain zero-delay non-blocking assignments.
    if (U_DLY < 0) begin : g_neg_u_dly_unsupported
    end

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    // Synchroniser, history and edge qualification
    (* ASYNC_REG = "TRUE" *) logic [CH_NUM-1:0] sync1;
    (* ASYNC_REG = "TRUE" *) logic [CH_NUM-1:0] sync2;
    logic [CH_NUM-1:0] hist;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic [CH_NUM-1:0] qual;

    // Pending slots
    logic [CH_NUM-1:0] pend;
    logic [CH_NUM-1:0] pend_type;
    logic [CH_NUM-1:0] cap;
    logic [CH_NUM-1:0] new_ovf;
    logic [CH_NUM-1:0] clr;

    // Arbiter and FSM
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   cand;
    logic              gnt_found;
    logic              load;
    state_t            state;
    state_t            state_nxt;

`ifdef CB_EDGE_ARB_TS_EN
    logic [TS_W-1:0]   ts_cnt;
    logic [TS_W-1:0]   pend_ts [CH_NUM];
`endif

    // Two-flop synchroniser followed by one history flop per channel
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Edge detection and per-channel edge_sel qualification
    always_comb begin
        rise = '0;
        fall = '0;
        qual = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            rise[i] = sync2[i] & ~hist[i];
            fall[i] = ~sync2[i] & hist[i];
            qual[i] = (rise[i] & edge_sel[2*i]) | (fall[i] & edge_sel[2*i+1]);
        end
    end

    // Capture a new edge when the slot is free or being emptied this cycle;
    // otherwise the new edge is an overflow and the original event is kept
    always_comb begin
        cap     = qual & (clr | ~pend);
        new_ovf = qual & pend & ~clr;
    end

    // Pending flags and latched edge type
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_type <= '0;
        end else begin
            pend <= (pend & ~clr) | cap;
            for (int i = 0; i < CH_NUM; i++) begin
                if (cap[i]) begin
                    pend_type[i] <= rise[i];
                end
            end
        end
    end

    // Sticky overflow flags; a coincident new overflow wins over the clear
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= '0;
        end else begin
            ovf_flag <= (ovf_flag & ~{CH_NUM{ovf_clr}}) | new_ovf;
        end
    end

`ifdef CB_EDGE_ARB_TS_EN
    // Free-running timestamp counter, wraps naturally at 2^TS_W
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    // Timestamp of each captured edge, taken in its detection cycle
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                pend_ts[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (cap[i]) begin
                    pend_ts[i] <= ts_cnt;
                end
            end
        end
    end
`endif

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            cand = rr_ptr + CH_W'(k);
            if (!gnt_found && pend[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (evt.evt_rdy && !gnt_found) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: valid flag, output-register load and slot clear strobe
    always_comb begin
        evt.evt_vld = (state == VALID);
        load        = gnt_found && ((state == IDLE) || evt.evt_rdy);
        clr         = '0;
        if (load) begin
            clr[gnt_idx] = 1'b1;
        end
    end

    // Last-granted pointer; reset value makes channel 0 first in line
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_W'(CH_NUM - 1);
        end else if (load) begin
            rr_ptr <= gnt_idx;
        end
    end

    // Output event register, only updated on load so it holds under back-pressure
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_ch   <= '0;
            evt.evt_type <= 1'b0;
        end else if (load) begin
            evt.evt_ch   <= gnt_idx;
            evt.evt_type <= pend_type[gnt_idx];
        end
    end

`ifdef CB_EDGE_ARB_TS_EN
    // Output timestamp register, loaded alongside channel and type
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_ts <= '0;
        end else if (load) begin
            evt.evt_ts <= pend_ts[gnt_idx];
        end
    end
`else
    assign evt.evt_ts = '0;
`endif

endmodule

// File: tb/tb_cb_edge_arb.sv
// Directed bench for cb_edge_arb (CH_NUM=4, TS_W=4) with hand-computed
// expectations; timestamp expectations collapse to 0 unless
// CB_EDGE_ARB_TS_EN is defined.
module tb_cb_edge_arb;

    localparam int CH_NUM = 4;
    localparam int TS_W   = 4;

    logic                clk_sys = 1'b0;
    logic                rst_n;
    logic [CH_NUM-1:0]   sig_in;
    logic [2*CH_NUM-1:0] edge_sel;
    logic [CH_NUM-1:0]   ovf_flag;
    logic                ovf_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int tb_cyc;
    int ts1;
    int ts2;

    cb_edge_arb_if #(.CH_NUM(CH_NUM), .TS_W(TS_W)) evt_if ();

    cb_edge_arb #(
        .U_DLY  (1),
        .CH_NUM (CH_NUM),
        .TS_W   (TS_W)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .edge_sel (edge_sel),
        .ovf_flag (ovf_flag),
        .ovf_clr  (ovf_clr),
        .evt      (evt_if)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference cycle count since reset release; equals the DUT time base
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    function automatic int ts_exp(input int v);
`ifdef CB_EDGE_ARB_TS_EN
        return v % 16;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_vld(input string tag, input int max);
        int n = 0;
        while (!evt_if.evt_vld && n < max) begin
            tick();
            n++;
        end
        check(tag, int'(evt_if.evt_vld), 1);
    endtask

    task automatic no_evt(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (evt_if.evt_vld) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    task automatic check_evt(input string tag, input int ch, input int typ, input int ts);
        check({tag, "_vld"},  int'(evt_if.evt_vld), 1);
        check({tag, "_ch"},   int'(evt_if.evt_ch), ch);
        check({tag, "_type"}, int'(evt_if.evt_type), typ);
        check({tag, "_ts"},   int'(evt_if.evt_ts), ts);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        sig_in         = '0;
        edge_sel       = '0;
        ovf_clr        = 1'b0;
        evt_if.evt_rdy = 1'b0;
        repeat (3) tick();
        check("rst_vld",  int'(evt_if.evt_vld), 0);
        check("rst_ch",   int'(evt_if.evt_ch), 0);
        check("rst_type", int'(evt_if.evt_type), 0);
        check("rst_ts",   int'(evt_if.evt_ts), 0);
        check("rst_ovf",  int'(ovf_flag), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // All four channels rise together: drained 0,1,2,3 back to back
        edge_sel       = 8'h55;
        evt_if.evt_rdy = 1'b1;
        sig_in         = 4'b1111;
        repeat (4) tick();
        check("rr4_ch0", int'(evt_if.evt_ch), 0);
        check("rr4_vld0", int'(evt_if.evt_vld), 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("rr4_ch%0d", k), int'(evt_if.evt_ch), k);
            check($sformatf("rr4_vld%0d", k), int'(evt_if.evt_vld), 1);
        end
        tick();
        check("rr4_idle", int'(evt_if.evt_vld), 0);
        sig_in = 4'b0000;
        no_evt("rr4_fall_ignored", 6);
        sig_in = 4'b1001;
        repeat (4) tick();
        check("rr2_first_ch0", int'(evt_if.evt_ch), 0);
        tick();
        check("rr2_second_ch3", int'(evt_if.evt_ch), 3);
        check("rr2_second_vld", int'(evt_if.evt_vld), 1);
        tick();
        check("rr2_idle", int'(evt_if.evt_vld), 0);

        // Single rising edge on ch1: valid exactly 4 clocks after the input change
        edge_sel  = 8'b0000_0100;
        ts1       = tb_cyc + 2;
        sig_in[1] = 1'b1;
        repeat (3) tick();
        check("lat_early", int'(evt_if.evt_vld), 0);
        tick();
        check_evt("lat_evt", 1, 1, ts_exp(ts1));
        tick();
        check("lat_idle", int'(evt_if.evt_vld), 0);
        sig_in[1] = 1'b0;
        no_evt("lat_fall_ignored", 8);

        // Back-pressure on ch2 (both edges): output holds, third edge overflows
        evt_if.evt_rdy = 1'b0;
        edge_sel       = 8'b0011_0000;
        ts1            = tb_cyc + 2;
        sig_in[2]      = 1'b1;
        repeat (4) tick();
        check_evt("bp_first", 2, 1, ts_exp(ts1));
        repeat (6) tick();
        ts2       = tb_cyc + 2;
        sig_in[2] = 1'b0;
        repeat (5) tick();
        check_evt("bp_hold1", 2, 1, ts_exp(ts1));
        check("bp_no_ovf", int'(ovf_flag), 0);
        repeat (5) tick();
        sig_in[2] = 1'b1;
        repeat (5) tick();
        check("bp_ovf", int'(ovf_flag), 4);
        check_evt("bp_hold2", 2, 1, ts_exp(ts1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_ovf_clr", int'(ovf_flag), 0);
        sig_in[2] = 1'b0;
        repeat (2) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_clr_vs_new_ovf", int'(ovf_flag), 4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_ovf_clr2", int'(ovf_flag), 0);
        evt_if.evt_rdy = 1'b1;
        tick();
        check_evt("bp_second", 2, 0, ts_exp(ts2));
        tick();
        check("bp_drained", int'(evt_if.evt_vld), 0);

        // Reset while an event is presented and others are pending
        evt_if.evt_rdy = 1'b0;
        edge_sel       = 8'hFF;
        sig_in         = 4'b0110;
        repeat (5) tick();
        check("mrst_pre_vld", int'(evt_if.evt_vld), 1);
        rst_n  = 1'b0;
        sig_in = 4'b0000;
        repeat (2) tick();
        check("mrst_vld",  int'(evt_if.evt_vld), 0);
        check("mrst_ch",   int'(evt_if.evt_ch), 0);
        check("mrst_type", int'(evt_if.evt_type), 0);
        check("mrst_ts",   int'(evt_if.evt_ts), 0);
        check("mrst_ovf",  int'(ovf_flag), 0);
        rst_n          = 1'b1;
        evt_if.evt_rdy = 1'b1;
        no_evt("mrst_no_events", 10);

        // Timestamp wrap: edges detected at ts 15 and 1 (TS_W=4)
        edge_sel = 8'b0000_0011;
        for (int i = 0; i < 16 && (tb_cyc % 16) != 13; i++) tick();
        check("wrap_align", tb_cyc % 16, 13);
        sig_in[0] = 1'b1;
        repeat (2) tick();
        sig_in[0] = 1'b0;
        wait_vld("wrap_ev1_seen", 8);
        check("wrap_ev1_type", int'(evt_if.evt_type), 1);
        check("wrap_ev1_ts", int'(evt_if.evt_ts), ts_exp(15));
        tick();
        wait_vld("wrap_ev2_seen", 8);
        check("wrap_ev2_ch", int'(evt_if.evt_ch), 0);
        check("wrap_ev2_type", int'(evt_if.evt_type), 0);
        check("wrap_ev2_ts", int'(evt_if.evt_ts), ts_exp(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
